// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry registered skid buffer between fetch and register read.
// Decodes every RV32I/RV64I immediate format plus shamt; stores only {imm, fmt} per entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam bit IS_RV64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic [6:0]      opcode;
  logic            is_shift;
  logic [31:0]     imm_i32;
  logic [31:0]     imm_s32;
  logic [31:0]     imm_b32;
  logic [31:0]     imm_u32;
  logic [31:0]     imm_j32;
  logic [XLEN-1:0] imm_d;
  fmt_t            fmt_d;

  assign opcode   = instr_in[6:0];
  // funct3 001 (SLL) and 101 (SRL/SRA) share bits [13:12] = 01
  assign is_shift = (instr_in[13:12] == 2'b01);
  assign imm_i32  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s32  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b32  = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u32  = {instr_in[31:12], 12'b0};
  assign imm_j32  = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

  always_comb begin
    fmt_d = FMT_ILL;
    imm_d = '0;
    case (opcode)
      OP_IMM: begin
        if (is_shift) begin
          fmt_d = FMT_SHAMT;
          imm_d = IS_RV64 ? XLEN'(instr_in[25:20]) : XLEN'(instr_in[24:20]);
        end else begin
          fmt_d = FMT_I;
          imm_d = sext32(imm_i32);
        end
      end
      OP_IMM32: begin
        if (IS_RV64) begin
          if (is_shift) begin
            fmt_d = FMT_SHAMT;
            imm_d = XLEN'(instr_in[24:20]);
          end else begin
            fmt_d = FMT_I;
            imm_d = sext32(imm_i32);
          end
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt_d = FMT_I;
        imm_d = sext32(imm_i32);
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm_d = sext32(imm_s32);
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm_d = sext32(imm_b32);
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm_d = sext32(imm_u32);
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm_d = sext32(imm_j32);
      end
      OP_REG: begin
        fmt_d = FMT_R;
      end
      OP_REG32: begin
        if (IS_RV64) fmt_d = FMT_R;
      end
      default: begin
        fmt_d = FMT_ILL;
      end
    endcase
  end

  logic [1:0]      count;
  logic [XLEN-1:0] head_imm;
  fmt_t            head_fmt;
  logic [XLEN-1:0] tail_imm;
  fmt_t            tail_fmt;
  logic            push;
  logic            pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign imm_out   = head_imm;
  assign fmt_out   = head_fmt;

  // The head register doubles as the output register, so it keeps its value when the buffer drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      head_imm <= '0;
      head_fmt <= FMT_R;
      tail_imm <= '0;
      tail_fmt <= FMT_R;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_imm <= imm_d;
            head_fmt <= fmt_d;
          end else begin
            tail_imm <= imm_d;
            tail_fmt <= fmt_d;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_imm <= tail_imm;
            head_fmt <= tail_fmt;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_imm <= imm_d;
            head_fmt <= fmt_d;
          end else begin
            head_imm <= tail_imm;
            head_fmt <= tail_fmt;
            tail_imm <= imm_d;
            tail_fmt <= fmt_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Counted on push regardless of flush: the word was accepted even if later discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_cnt <= '0;
    end else if (push && (fmt_d == FMT_ILL) && !(&illegal_cnt)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: table of decode vectors plus handshake, flush, counter and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm_out;
  logic [2:0]  fmt_out;
  logic [15:0] illegal_cnt;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic [63:0] imm_out2;
  logic [2:0]  fmt_out2;
  logic [1:0]  illegal_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .fmt_out(fmt_out), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .instr_in(32'h0000_0000),
    .out_valid(out_valid2), .out_ready(1'b1),
    .imm_out(imm_out2), .fmt_out(fmt_out2), .illegal_cnt(illegal_cnt2)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}; // addi -1
    vecs[1]  = '{32'h0031_0263, 64'h0000_0000_0000_0004, 3'd3}; // beq +4
    vecs[2]  = '{32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 3'd4}; // lui
    vecs[3]  = '{32'hFFDF_F06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5}; // jal -4
    vecs[4]  = '{32'h03F0_9093, 64'h0000_0000_0000_003F, 3'd6}; // slli 63
    vecs[5]  = '{32'hFE20_AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2}; // sw -8
    vecs[6]  = '{32'h0020_81B3, 64'h0000_0000_0000_0000, 3'd0}; // add
    vecs[7]  = '{32'h1234_5097, 64'h0000_0000_1234_5000, 3'd4}; // auipc
    vecs[8]  = '{32'h0050_809B, 64'h0000_0000_0000_0005, 3'd1}; // addiw 5
    vecs[9]  = '{32'h03F0_909B, 64'h0000_0000_0000_001F, 3'd6}; // slliw, bit 25 ignored
    vecs[10] = '{32'h4030_D093, 64'h0000_0000_0000_0003, 3'd6}; // srai 3
    vecs[11] = '{32'h7FF0_A083, 64'h0000_0000_0000_07FF, 3'd1}; // lw 2047
    vecs[12] = '{32'h0000_0073, 64'h0000_0000_0000_0000, 3'd1}; // ecall
    vecs[13] = '{32'h8000_80E7, 64'hFFFF_FFFF_FFFF_F800, 3'd1}; // jalr -2048
    vecs[14] = '{32'h0020_80BB, 64'h0000_0000_0000_0000, 3'd0}; // addw
    vecs[15] = '{32'h0010_00EF, 64'h0000_0000_0000_0800, 3'd5}; // jal +2048
    vecs[16] = '{32'h0000_00E3, 64'h0000_0000_0000_0800, 3'd3}; // beq +2048

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr_in = '0; out_ready = 1'b0;
    in_valid2 = 1'b0;
    step(); step();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset imm", imm_out, 64'd0);
    chk("reset fmt", 64'(fmt_out), 64'd0);
    chk("reset illegal_cnt", 64'(illegal_cnt), 64'd0);
    reset_n = 1'b1;
    step();

    // Decode table: push one word, check the head one edge later, then let it pop.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      instr_in = vecs[i].instr;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d imm", i), imm_out, vecs[i].imm);
      chk($sformatf("vec%0d fmt", i), 64'(fmt_out), 64'(vecs[i].fmt));
      step();
      chk($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
    end
    chk("table held imm", imm_out, 64'h0000_0000_0000_0800);
    chk("table illegal_cnt", 64'(illegal_cnt), 64'd0);

    // Backpressure: A, B accepted, C held until space frees, then in-order drain.
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr_in = 32'h0031_0263;
    step();
    chk("bp A in_ready", 64'(in_ready), 64'd1);
    chk("bp A head", imm_out, 64'd4);
    instr_in = 32'h8000_00B7;
    step();
    chk("bp full in_ready", 64'(in_ready), 64'd0);
    chk("bp full head", imm_out, 64'd4);
    instr_in = 32'h03F0_9093;
    step();
    chk("bp hold in_ready", 64'(in_ready), 64'd0);
    chk("bp hold head", imm_out, 64'd4);
    chk("bp hold fmt", 64'(fmt_out), 64'd3);
    out_ready = 1'b1;
    step();
    chk("bp B head", imm_out, 64'hFFFF_FFFF_8000_0000);
    chk("bp B in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp C head", imm_out, 64'd63);
    chk("bp C valid", 64'(out_valid), 64'd1);
    step();
    chk("bp drained", 64'(out_valid), 64'd0);
    chk("bp hold after drain", imm_out, 64'd63);

    // Illegal words counted on push.
    instr_in = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("ill%0d fmt", i), 64'(fmt_out), 64'd7);
      chk($sformatf("ill%0d imm", i), imm_out, 64'd0);
      step();
    end
    chk("illegal_cnt 3", 64'(illegal_cnt), 64'd3);

    // Flush at count=2 with a word offered: dropped, in_ready shows pre-flush count.
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr_in = 32'hFFF0_0093;
    step(); step();
    instr_in = 32'h0000_007F;
    flush = 1'b1;
    #1;
    chk("flush pre in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush dropped illegal", 64'(illegal_cnt), 64'd3);

    // Illegal word pushed alongside flush still counts but is not buffered.
    flush = 1'b1;
    in_valid = 1'b1;
    instr_in = 32'h0000_0000;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush push out_valid", 64'(out_valid), 64'd0);
    chk("flush push illegal_cnt", 64'(illegal_cnt), 64'd4);

    // Saturating counter on the CNT_W=2 instance.
    in_valid2 = 1'b1;
    repeat (5) step();
    in_valid2 = 1'b0;
    chk("sat illegal_cnt", 64'(illegal_cnt2), 64'd3);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    instr_in = 32'hFFDF_F06F;
    step();
    in_valid = 1'b0;
    chk("pre-reset valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async imm", imm_out, 64'd0);
    chk("async fmt", 64'(fmt_out), 64'd0);
    chk("async illegal_cnt", 64'(illegal_cnt), 64'd0);
    chk("async sat cnt", 64'(illegal_cnt2), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("resume empty", 64'(out_valid), 64'd0);
    chk("resume in_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
